// File: rtl/irq_pkg.sv
// irq_pkg: shared width, register map and vector type for the interrupt controller
package irq_pkg;
    localparam int N_IRQ = 8;
    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_PEND = 2'd1;
    localparam logic [1:0] ADDR_ISR  = 2'd2;
    localparam logic [1:0] ADDR_MODE = 2'd3;
    typedef logic [N_IRQ-1:0] irq_vec_t;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: one-hot of the highest set bit, zero when no bit is set
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int W = N_IRQ
) (
    input  logic [W-1:0] in_vec,
    output logic [W-1:0] onehot
);
    always_comb begin
        onehot = '0;
        for (int i = 0; i < W; i++)
            if (in_vec[i]) onehot = W'(1) << i;
    end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: CP0 hardware-interrupt source with sync, pending, mask, fixed priority and nesting
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter logic [N_IRQ-1:0] MODE_RST = '1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [N_IRQ-1:0] irq_src,
    input  logic             wr_en,
    input  logic [1:0]       addr,
    input  logic [N_IRQ-1:0] wr_data,
    output logic [N_IRQ-1:0] rd_data,
    output logic [N_IRQ-1:0] hardware_interrupt,
    input  logic             interrupt,
    input  logic             eret
);
    irq_vec_t sync_q [SYNC_STAGES];
    irq_vec_t s_d, pend, isr, mask, mode;
    irq_vec_t rise, acc, w1c, isr_top, above, elig, pick, pend_n, isr_n;
    logic taken;

    assign taken = interrupt && |hardware_interrupt;
    assign acc = taken ? hardware_interrupt : '0;
    assign w1c = (wr_en && addr == ADDR_PEND) ? wr_data : '0;
    assign rise = sync_q[SYNC_STAGES-1] & ~s_d;
    assign pend_n = (mode & (rise | (pend & ~acc & ~w1c))) | (~mode & sync_q[SYNC_STAGES-1]);
    assign above = (isr == '0) ? '1 : ~(isr_top | (isr_top - irq_vec_t'(1)));
    assign elig = pend & mask & above;
    assign isr_n = (eret ? isr & ~isr_top : isr) | acc;
    assign rd_data = addr == ADDR_MASK ? mask :
                     addr == ADDR_PEND ? pend :
                     addr == ADDR_ISR  ? isr  : mode;

    irq_prio_enc #(.W(N_IRQ)) u_elig (.in_vec(elig), .onehot(pick));
    irq_prio_enc #(.W(N_IRQ)) u_isr  (.in_vec(isr),  .onehot(isr_top));

    // An accepted request is dropped for one cycle so cp0 never sees it twice
    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            s_d <= '0;
            pend <= '0;
            isr <= '0;
            mask <= '0;
            mode <= MODE_RST;
            hardware_interrupt <= '0;
        end else begin
            sync_q[0] <= irq_src;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            s_d <= sync_q[SYNC_STAGES-1];
            pend <= pend_n;
            isr <= isr_n;
            hardware_interrupt <= taken ? '0 : pick;
            if (wr_en && addr == ADDR_MASK) mask <= wr_data;
            if (wr_en && addr == ADDR_MODE) mode <= wr_data;
        end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed literal checks plus random traffic compared each cycle to a behavioural model
module tb_irq_ctrl;
    localparam int N = 8;
    localparam int S = 2;

    logic clk = 0, clr_n = 0, wr_en = 0, interrupt = 0, eret = 0;
    logic [1:0] addr = 0;
    logic [7:0] irq_src = 0, wr_data = 0, rd_data, hw;
    int errors = 0, checks = 0;

    irq_ctrl #(.SYNC_STAGES(S), .MODE_RST(8'hFF)) dut (
        .clk(clk), .clr_n(clr_n), .irq_src(irq_src), .wr_en(wr_en), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .hardware_interrupt(hw),
        .interrupt(interrupt), .eret(eret)
    );

    always #5 clk = ~clk;

    logic [7:0] m_sync [S];
    logic [7:0] m_sd, m_pend, m_isr, m_mask, m_mode, m_hw;

    function automatic int top_idx(logic [7:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [7:0] next_pend(logic [7:0] s, sd, p, md, ac, wc);
        logic [7:0] r;
        for (int i = 0; i < N; i++)
            r[i] = md[i] ? ((s[i] && !sd[i]) || (p[i] && !ac[i] && !wc[i])) : s[i];
        return r;
    endfunction

    function automatic logic [7:0] next_isr(logic [7:0] is, h, logic it, logic er);
        logic [7:0] r = is;
        int t = top_idx(is);
        if (er && t >= 0) r[t] = 1'b0;
        if (it && h != 0) r[top_idx(h)] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] next_hw(logic [7:0] p, mk, is, h, logic it);
        int t = top_idx(is);
        if (it && h != 0) return 8'h00;
        for (int i = N - 1; i > t; i--) if (p[i] && mk[i]) return 8'h01 << i;
        return 8'h00;
    endfunction

    function automatic logic [7:0] exp_rd(logic [1:0] a);
        return a == 0 ? m_mask : a == 1 ? m_pend : a == 2 ? m_isr : m_mode;
    endfunction

    always @(posedge clk or negedge clr_n)
        if (!clr_n) begin
            for (int k = 0; k < S; k++) m_sync[k] <= 0;
            m_sd <= 0;
            m_pend <= 0;
            m_isr <= 0;
            m_mask <= 0;
            m_mode <= 8'hFF;
            m_hw <= 0;
        end else begin
            m_sync[0] <= irq_src;
            for (int k = 1; k < S; k++) m_sync[k] <= m_sync[k-1];
            m_sd <= m_sync[S-1];
            m_pend <= next_pend(m_sync[S-1], m_sd, m_pend, m_mode,
                                (interrupt && m_hw != 0) ? m_hw : 8'h00,
                                (wr_en && addr == 1) ? wr_data : 8'h00);
            m_isr <= next_isr(m_isr, m_hw, interrupt, eret);
            m_hw <= next_hw(m_pend, m_mask, m_isr, m_hw, interrupt);
            if (wr_en && addr == 0) m_mask <= wr_data;
            if (wr_en && addr == 3) m_mode <= wr_data;
        end

    task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_hw", hw, m_hw);
        check("model_rd", rd_data, exp_rd(addr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    task automatic wr(logic [1:0] a, logic [7:0] d);
        wr_en = 1; addr = a; wr_data = d;
        tick();
        wr_en = 0;
    endtask

    task automatic rd_chk(string nm, logic [1:0] a, logic [7:0] e);
        addr = a;
        #1;
        check(nm, rd_data, e);
    endtask

    task automatic pulse(logic [7:0] v);
        irq_src = v;
        tick();
        irq_src = 0;
    endtask

    task automatic accept();
        interrupt = 1;
        tick();
        interrupt = 0;
    endtask

    task automatic do_eret();
        eret = 1;
        tick();
        eret = 0;
    endtask

    initial begin
        ticks(2);
        clr_n = 1;
        check("rst_hw", hw, 8'h00);
        rd_chk("rst_mask", 0, 8'h00);
        rd_chk("rst_mode", 3, 8'hFF);
        rd_chk("rst_pend", 1, 8'h00);
        rd_chk("rst_isr", 2, 8'h00);

        wr_en = 1; addr = 0; wr_data = 8'hFF;
        #1;
        check("rd_old_on_write", rd_data, 8'h00);
        tick();
        wr_en = 0;
        rd_chk("mask_ff", 0, 8'hFF);
        pulse(8'h08);
        check("lat_e0", hw, 8'h00);
        tick();
        check("lat_e1", hw, 8'h00);
        tick();
        check("lat_e2", hw, 8'h00);
        tick();
        check("lat_e3", hw, 8'h08);
        accept();
        rd_chk("lat_isr", 2, 8'h08);
        do_eret();
        rd_chk("lat_isr_pop", 2, 8'h00);

        pulse(8'h24);
        ticks(3);
        check("prio_hw", hw, 8'h20);
        accept();
        check("prio_acc_hw", hw, 8'h00);
        rd_chk("prio_isr", 2, 8'h20);
        tick();
        check("prio_blocked", hw, 8'h00);
        do_eret();
        rd_chk("prio_isr_pop", 2, 8'h00);
        tick();
        check("prio_low", hw, 8'h04);
        accept();
        rd_chk("nest_isr2", 2, 8'h04);

        pulse(8'h40);
        ticks(3);
        check("nest_hw", hw, 8'h40);
        accept();
        rd_chk("nest_isr", 2, 8'h44);
        tick();
        do_eret();
        rd_chk("nest_pop", 2, 8'h04);
        pulse(8'h02);
        ticks(4);
        check("nest_block", hw, 8'h00);
        rd_chk("nest_pend", 1, 8'h02);
        do_eret();
        tick();
        check("nest_unblock", hw, 8'h02);
        accept();
        do_eret();
        rd_chk("nest_empty", 2, 8'h00);

        wr(0, 8'h00);
        pulse(8'h10);
        ticks(3);
        check("mask_hw", hw, 8'h00);
        rd_chk("mask_pend", 1, 8'h10);
        wr(1, 8'h10);
        rd_chk("w1c_clear", 1, 8'h00);
        pulse(8'h10);
        tick();
        wr(1, 8'h10);
        rd_chk("w1c_set_wins", 1, 8'h10);
        wr(1, 8'h10);
        rd_chk("w1c_again", 1, 8'h00);

        wr(0, 8'hFF);
        wr(3, 8'h00);
        irq_src = 8'h01;
        ticks(4);
        check("lvl_hw", hw, 8'h01);
        accept();
        check("lvl_acc_hw", hw, 8'h00);
        rd_chk("lvl_isr", 2, 8'h01);
        tick();
        check("lvl_blocked", hw, 8'h00);
        do_eret();
        tick();
        check("lvl_persist", hw, 8'h01);
        irq_src = 0;
        ticks(4);
        check("lvl_drop", hw, 8'h00);
        irq_src = 8'h01;
        ticks(4);
        accept();
        irq_src = 8'h21;
        ticks(4);
        check("lvl_nest_hw", hw, 8'h20);
        interrupt = 1; eret = 1;
        tick();
        interrupt = 0; eret = 0;
        rd_chk("push_pop_isr", 2, 8'h20);

        clr_n = 0;
        #1;
        check("mid_rst_hw", hw, 8'h00);
        rd_chk("mid_rst_mask", 0, 8'h00);
        rd_chk("mid_rst_mode", 3, 8'hFF);
        rd_chk("mid_rst_pend", 1, 8'h00);
        rd_chk("mid_rst_isr", 2, 8'h00);
        tick();
        clr_n = 1;
        irq_src = 0;
        ticks(3);
        rd_chk("post_rst_isr", 2, 8'h00);

        wr(0, 8'hFF);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(3) == 0) irq_src = 8'($urandom);
            interrupt = $urandom_range(2) == 0;
            eret = $urandom_range(5) == 0;
            wr_en = $urandom_range(9) == 0;
            addr = 2'($urandom);
            wr_data = 8'($urandom);
            clr_n = $urandom_range(399) != 0;
            tick();
        end
        interrupt = 0; eret = 0; wr_en = 0; clr_n = 1;
        ticks(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
